// File: rtl/req_arbiter4_pkg.sv
// Shared constants and FSM state encoding for the four-way round-robin arbiter.
package req_arbiter4_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/req_arbiter4_rr_pick4.sv
// Combinational round-robin picker: first set pending bit scanning ptr+1, ptr+2, ... (mod 4).
module rr_pick4
  import req_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] pend,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] pick,
  output logic [1:0]       pick_idx,
  output logic             any
);

  logic [1:0] w_idx;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    w_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = ptr + 2'(i);
      if (!any && pend[w_idx]) begin
        pick[w_idx] = 1'b1;
        pick_idx    = w_idx;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter4.sv
// Round-robin arbiter for four requesters: captures request pulses, holds a registered
// one-hot grant until done, inserts a one-cycle gap, and releases stuck grants via a watchdog.
module req_arbiter4
  import req_arbiter4_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout_err,
  output logic [N_REQ-1:0] pend_o
);

  localparam logic [TW-1:0] LP_TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic          LP_WD_EN    = (TIMEOUT != 0);

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0] r_pend, w_pend_nxt;
  logic [N_REQ-1:0] w_clr, w_pick;
  logic [1:0]       r_gnt_idx, w_gnt_idx_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt, w_pick_idx;
  logic [TW-1:0]    r_timer, w_timer_nxt;
  logic             r_terr, w_terr_nxt;
  logic             w_any, w_wd_fire;

  rr_pick4 u_pick (
    .pend     (r_pend),
    .ptr      (r_ptr),
    .pick     (w_pick),
    .pick_idx (w_pick_idx),
    .any      (w_any)
  );

  assign w_wd_fire = LP_WD_EN && (r_timer == LP_TMO_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    w_timer_nxt   = r_timer;
    w_terr_nxt    = 1'b0;
    w_clr         = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt     = w_pick;
          w_gnt_idx_nxt = w_pick_idx;
          w_timer_nxt   = '0;
          w_state_nxt   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (r_timer != '1) w_timer_nxt = r_timer + 1'b1;
        // done takes priority over the watchdog, so a same-edge collision reports no error.
        if (done || w_wd_fire) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_gnt_idx;
          w_clr       = r_gnt;
          w_terr_nxt  = !done;
          w_state_nxt = ST_GAP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The grantee's own request is masked; clearing the released bit wins over a new set.
    w_pend_nxt = (r_pend | (req & ~r_gnt)) & ~w_clr;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_pend    <= '0;
      r_ptr     <= 2'd3;
      r_timer   <= '0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_pend    <= w_pend_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timer   <= w_timer_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_valid   = |r_gnt;
  assign timeout_err = r_terr;
  assign pend_o      = r_pend;

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4: two instances (watchdog off / TIMEOUT=4) driven from vector tables.
module tb_req_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic       done_a = 1'b0, done_b = 1'b0;
  logic [3:0] gnt_a, gnt_b, pend_a, pend_b;
  logic       gv_a, gv_b, terr_a, terr_b;

  always #5 clk = ~clk;

  req_arbiter4 #(.TIMEOUT(0), .TW(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_valid(gv_a), .timeout_err(terr_a), .pend_o(pend_a)
  );

  req_arbiter4 #(.TIMEOUT(4), .TW(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_valid(gv_b), .timeout_err(terr_b), .pend_o(pend_b)
  );

  typedef struct {
    logic       sel_b;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [3:0] pend;
    logic       terr;
    string      name;
  } vec_t;

  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel_b, input logic [3:0] r, input logic d,
                              input logic [3:0] g, input logic [3:0] p, input logic t,
                              input string n);
    vec_t v;
    v.sel_b = sel_b; v.req = r; v.done = d;
    v.gnt = g; v.pend = p; v.terr = t; v.name = n;
    return v;
  endfunction

  // Outputs are sampled on the falling edge, after the rising edge that consumed the inputs.
  task automatic compare_next();
    vec_t       e;
    logic [3:0] ag, ap;
    logic       av, at;
    e  = sb.pop_front();
    ag = e.sel_b ? gnt_b  : gnt_a;
    ap = e.sel_b ? pend_b : pend_a;
    av = e.sel_b ? gv_b   : gv_a;
    at = e.sel_b ? terr_b : terr_a;
    check({e.name, ".gnt"},   32'(ag), 32'(e.gnt));
    check({e.name, ".valid"}, 32'(av), 32'(|e.gnt));
    check({e.name, ".pend"},  32'(ap), 32'(e.pend));
    check({e.name, ".terr"},  32'(at), 32'(e.terr));
    check({e.name, ".onehot"}, 32'($onehot0(ag)), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    if (v.sel_b) begin
      req_b = v.req; done_b = v.done;
    end else begin
      req_a = v.req; done_a = v.done;
    end
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    compare_next();
  endtask

  task automatic run_table(input vec_t tbl[$]);
    foreach (tbl[i]) drive(tbl[i]);
  endtask

  // Asserts reset between edges, checks both DUTs cleared immediately, releases at the next falling edge.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, ".gnt_a"},  32'(gnt_a),  32'd0);
    check({name, ".pend_a"}, 32'(pend_a), 32'd0);
    check({name, ".gv_a"},   32'(gv_a),   32'd0);
    check({name, ".gnt_b"},  32'(gnt_b),  32'd0);
    check({name, ".pend_b"}, 32'(pend_b), 32'd0);
    @(negedge clk);
    req_a = '0; done_a = 1'b0; req_b = '0; done_b = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t t_rst[$], t_rot[$], t_single[$], t_wd[$], t_col[$], t_pulse[$];

    t_rst = '{
      mk(0, 4'b0001, 0, 4'b0000, 4'b0001, 0, "rst.e0"),
      mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 0, "rst.e1")
    };
    t_rot = '{
      mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, "rot.e0"),
      mk(0, 4'b1111, 0, 4'b0001, 4'b1111, 0, "rot.e1"),
      mk(0, 4'b1111, 0, 4'b0001, 4'b1111, 0, "rot.e2"),
      mk(0, 4'b1111, 1, 4'b0000, 4'b1110, 0, "rot.e3"),
      mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, "rot.e4"),
      mk(0, 4'b1111, 0, 4'b0010, 4'b1111, 0, "rot.e5"),
      mk(0, 4'b1111, 0, 4'b0010, 4'b1111, 0, "rot.e6"),
      mk(0, 4'b1111, 1, 4'b0000, 4'b1101, 0, "rot.e7"),
      mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, "rot.e8"),
      mk(0, 4'b1111, 0, 4'b0100, 4'b1111, 0, "rot.e9"),
      mk(0, 4'b1111, 0, 4'b0100, 4'b1111, 0, "rot.e10"),
      mk(0, 4'b1111, 1, 4'b0000, 4'b1011, 0, "rot.e11"),
      mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, "rot.e12"),
      mk(0, 4'b1111, 0, 4'b1000, 4'b1111, 0, "rot.e13"),
      mk(0, 4'b1111, 0, 4'b1000, 4'b1111, 0, "rot.e14"),
      mk(0, 4'b1111, 1, 4'b0000, 4'b0111, 0, "rot.e15"),
      mk(0, 4'b1111, 0, 4'b0000, 4'b1111, 0, "rot.e16"),
      mk(0, 4'b1111, 0, 4'b0001, 4'b1111, 0, "rot.e17")
    };
    t_single = '{
      mk(0, 4'b0100, 0, 4'b0000, 4'b0100, 0, "single.e0"),
      mk(0, 4'b0000, 0, 4'b0100, 4'b0100, 0, "single.e1"),
      mk(0, 4'b0000, 0, 4'b0100, 4'b0100, 0, "single.e2"),
      mk(0, 4'b0000, 0, 4'b0100, 4'b0100, 0, "single.e3"),
      mk(0, 4'b0000, 0, 4'b0100, 4'b0100, 0, "single.e4"),
      mk(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, "single.e5"),
      mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, "single.e6"),
      mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, "single.e7"),
      mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, "single.e8")
    };
    t_wd = '{
      mk(1, 4'b0010, 0, 4'b0000, 4'b0010, 0, "wd.e0"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "wd.e1"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "wd.e2"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "wd.e3"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "wd.e4"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 1, "wd.e5"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, "wd.e6"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, "wd.e7"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, "wd.e8")
    };
    t_col = '{
      mk(1, 4'b0010, 0, 4'b0000, 4'b0010, 0, "col.e0"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "col.e1"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "col.e2"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "col.e3"),
      mk(1, 4'b0000, 0, 4'b0010, 4'b0010, 0, "col.e4"),
      mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, "col.e5"),
      mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, "col.e6"),
      mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, "col.e7"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, "col.e8")
    };
    t_pulse = '{
      mk(1, 4'b0001, 1, 4'b0000, 4'b0001, 0, "pulse.e0"),
      mk(1, 4'b0000, 1, 4'b0001, 4'b0001, 0, "pulse.e1"),
      mk(1, 4'b1000, 0, 4'b0001, 4'b1001, 0, "pulse.e2"),
      mk(1, 4'b0000, 0, 4'b0001, 4'b1001, 0, "pulse.e3"),
      mk(1, 4'b0000, 1, 4'b0000, 4'b1000, 0, "pulse.e4"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b1000, 0, "pulse.e5"),
      mk(1, 4'b0000, 0, 4'b1000, 4'b1000, 0, "pulse.e6"),
      mk(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, "pulse.e7"),
      mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 0, "pulse.e8")
    };

    // Reset state, observed while reset is held.
    @(negedge clk);
    @(negedge clk);
    check("reset.gnt_a",  32'(gnt_a),  32'd0);
    check("reset.gv_a",   32'(gv_a),   32'd0);
    check("reset.terr_a", 32'(terr_a), 32'd0);
    check("reset.pend_a", 32'(pend_a), 32'd0);
    check("reset.gnt_b",  32'(gnt_b),  32'd0);
    check("reset.terr_b", 32'(terr_b), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-grant, then idle with no requests.
    run_table(t_rst);
    async_reset("rst.async");
    for (int i = 0; i < 3; i++)
      drive(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 0, $sformatf("rst.idle%0d", i)));

    run_table(t_rot);
    async_reset("rot.reset");

    run_table(t_single);
    run_table(t_wd);
    run_table(t_col);
    run_table(t_pulse);

    check("sb.drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
